mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 48 ++++
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-wide RAM port arbiter.
// Covers FSM state codes, grant owner, mem_len codes and lane helpers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_RD  = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_t;

    localparam logic [1:0] LEN_BYTE  = 2'd0;
    localparam logic [1:0] LEN_HALF  = 2'd1;
    localparam logic [1:0] LEN_WORD  = 2'd3;
    localparam logic       RAM_READ  = 1'b0;
    localparam logic       RAM_WRITE = 1'b1;
    localparam logic [2:0] IF_BYTES  = 3'd4;

    // Code 2 is reserved and behaves as a full word.
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_BYTE: n = 3'd1;
            LEN_HALF: n = 3'd2;
            LEN_WORD: n = 3'd4;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
        return word[{k, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] put_lane(input logic [31:0] word, input logic [1:0] k,
                                             input logic [7:0] b);
        logic [31:0] w;
        w = word;
        w[{k, 3'b000} +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one synchronous byte-wide RAM port between instruction fetch
// (4-byte reads) and the data side (1/2/4-byte reads and writes).
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din_ram,
    output logic [7:0]  dout_ram,
    output logic [31:0] addr_ram,
    output logic        wr_ram,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata
);

    arb_state_t  state_r, state_nxt_s;
    grant_t      last_grant_r, last_grant_nxt_s;
    logic [31:0] wdata_r, wdata_nxt_s;
    logic [2:0]  nbytes_r, nbytes_nxt_s;
    logic [2:0]  cnt_r, cnt_nxt_s;
    logic [31:0] rd_buf_r, rd_buf_nxt_s;

    logic [31:0] addr_ram_nxt_s, if_data_nxt_s, mem_rdata_nxt_s;
    logic [7:0]  dout_ram_nxt_s;
    logic        wr_ram_nxt_s, if_done_nxt_s, mem_done_nxt_s;

    logic        if_cand_s, mem_cand_s, grant_mem_s, grant_if_s;
    logic        rd_last_s, wr_last_s, if_abort_s;
    logic [1:0]  rd_lane_s;
    logic [31:0] rd_word_s;

    // A requester still showing its done pulse is finishing, not asking again.
    assign if_cand_s   = if_req & ~if_done & ~if_flush;
    assign mem_cand_s  = mem_req & ~mem_done;
    assign grant_mem_s = mem_cand_s & (~if_cand_s | (last_grant_r == GNT_IF));
    assign grant_if_s  = if_cand_s & ~grant_mem_s;

    // cnt_r counts edges since grant; byte k arrives on din_ram when cnt_r == k+1.
    assign rd_last_s  = (cnt_r == nbytes_r);
    assign wr_last_s  = (cnt_r == (nbytes_r - 3'd1));
    assign if_abort_s = (state_r == ST_IF_RD) & if_flush;
    assign rd_lane_s  = cnt_r[1:0] - 2'd1;
    assign rd_word_s  = put_lane(rd_buf_r, rd_lane_s, din_ram);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: only IDLE accepts work, flush is the sole early exit.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_mem_s) begin
                    state_nxt_s = (mem_we == RAM_WRITE) ? ST_MEM_WR : ST_MEM_RD;
                end else if (grant_if_s) begin
                    state_nxt_s = ST_IF_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_IF_RD: begin
                if (if_flush || rd_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_IF_RD;
                end
            end
            ST_MEM_RD: begin
                if (rd_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_MEM_RD;
                end
            end
            ST_MEM_WR: begin
                if (wr_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_MEM_WR;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output and datapath next values; everything leaves through registers.
    always_comb begin
        last_grant_nxt_s = last_grant_r;
        wdata_nxt_s      = wdata_r;
        nbytes_nxt_s     = nbytes_r;
        cnt_nxt_s        = cnt_r;
        rd_buf_nxt_s     = rd_buf_r;
        addr_ram_nxt_s   = addr_ram;
        dout_ram_nxt_s   = 8'h00;
        wr_ram_nxt_s     = RAM_READ;
        if_done_nxt_s    = 1'b0;
        mem_done_nxt_s   = 1'b0;
        if_data_nxt_s    = if_data;
        mem_rdata_nxt_s  = mem_rdata;
        case (state_r)
            ST_IDLE: begin
                if (grant_mem_s) begin
                    last_grant_nxt_s = GNT_MEM;
                    addr_ram_nxt_s   = mem_addr;
                    wdata_nxt_s      = mem_wdata;
                    nbytes_nxt_s     = len_to_bytes(mem_len);
                    cnt_nxt_s        = 3'd0;
                    rd_buf_nxt_s     = 32'h0000_0000;
                    if (mem_we == RAM_WRITE) begin
                        wr_ram_nxt_s   = RAM_WRITE;
                        dout_ram_nxt_s = byte_lane(mem_wdata, 2'd0);
                    end else begin
                        wr_ram_nxt_s   = RAM_READ;
                    end
                end else if (grant_if_s) begin
                    last_grant_nxt_s = GNT_IF;
                    addr_ram_nxt_s   = if_addr;
                    nbytes_nxt_s     = IF_BYTES;
                    cnt_nxt_s        = 3'd0;
                    rd_buf_nxt_s     = 32'h0000_0000;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_IF_RD, ST_MEM_RD: begin
                cnt_nxt_s = cnt_r + 3'd1;
                if (cnt_r != 3'd0) begin
                    rd_buf_nxt_s = rd_word_s;
                end else begin
                    rd_buf_nxt_s = rd_buf_r;
                end
                if (cnt_r < nbytes_r) begin
                    addr_ram_nxt_s = addr_ram + 32'd1;
                end else begin
                    addr_ram_nxt_s = addr_ram;
                end
                if (rd_last_s && !if_abort_s) begin
                    if (state_r == ST_IF_RD) begin
                        if_done_nxt_s = 1'b1;
                        if_data_nxt_s = rd_word_s;
                    end else begin
                        mem_done_nxt_s  = 1'b1;
                        mem_rdata_nxt_s = rd_word_s;
                    end
                end else begin
                    if_done_nxt_s = 1'b0;
                end
            end
            ST_MEM_WR: begin
                if (wr_last_s) begin
                    mem_done_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s      = cnt_r + 3'd1;
                    addr_ram_nxt_s = addr_ram + 32'd1;
                    wr_ram_nxt_s   = RAM_WRITE;
                    dout_ram_nxt_s = byte_lane(wdata_r, cnt_r[1:0] + 2'd1);
                end
            end
            default: begin
                cnt_nxt_s = 3'd0;
            end
        endcase
    end

    // Datapath and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= GNT_IF;
            wdata_r      <= 32'h0000_0000;
            nbytes_r     <= 3'd0;
            cnt_r        <= 3'd0;
            rd_buf_r     <= 32'h0000_0000;
            addr_ram     <= 32'h0000_0000;
            dout_ram     <= 8'h00;
            wr_ram       <= 1'b0;
            if_done      <= 1'b0;
            if_data      <= 32'h0000_0000;
            mem_done     <= 1'b0;
            mem_rdata    <= 32'h0000_0000;
        end else begin
            last_grant_r <= last_grant_nxt_s;
            wdata_r      <= wdata_nxt_s;
            nbytes_r     <= nbytes_nxt_s;
            cnt_r        <= cnt_nxt_s;
            rd_buf_r     <= rd_buf_nxt_s;
            addr_ram     <= addr_ram_nxt_s;
            dout_ram     <= dout_ram_nxt_s;
            wr_ram       <= wr_ram_nxt_s;
            if_done      <= if_done_nxt_s;
            if_data      <= if_data_nxt_s;
            mem_done     <= mem_done_nxt_s;
            mem_rdata    <= mem_rdata_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous byte RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din_ram, dout_ram;
    logic [31:0] addr_ram;
    logic        wr_ram;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_addr, if_data;
    logic        mem_req, mem_we, mem_done;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_err = 0;
    int if_pulses = 0, mem_pulses = 0, both_hi = 0, long_pulse = 0;
    logic if_done_q = 1'b0, mem_done_q = 1'b0;

    logic [7:0]  ram [0:8191];
    logic        pre_we;
    logic [31:0] pre_a;
    logic [7:0]  pre_d;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .din_ram(din_ram), .dout_ram(dout_ram), .addr_ram(addr_ram), .wr_ram(wr_ram),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    // Sparse address map: every address this bench touches lands on a unique slot.
    function automatic logic [12:0] ram_idx(input logic [31:0] a);
        return {a[14:12], a[9:0]};
    endfunction

    // Synchronous RAM: address sampled at the edge, data out the following cycle.
    always @(posedge clk) begin
        if (pre_we) ram[ram_idx(pre_a)] <= pre_d;
        else if (wr_ram) ram[ram_idx(addr_ram)] <= dout_ram;
        din_ram <= ram[ram_idx(addr_ram)];
    end

    // Done-pulse bookkeeping: counts, overlap and stretched pulses.
    always @(negedge clk) begin
        if_done_q  <= if_done;
        mem_done_q <= mem_done;
        if (if_done) if_pulses <= if_pulses + 1;
        if (mem_done) mem_pulses <= mem_pulses + 1;
        if (if_done && mem_done) both_hi <= both_hi + 1;
        if ((if_done && if_done_q) || (mem_done && mem_done_q)) long_pulse <= long_pulse + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic mem_start(input logic we, input logic [1:0] len, input logic [31:0] a,
                             input logic [31:0] wd);
        mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd; mem_req = 1'b1;
    endtask

    // First edge is the grant edge; latency is counted in edges after it.
    task automatic wait_done(input string tag, input bit on_if, input int exp_lat);
        int  n;
        bit  seen;
        n = 0; seen = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 16 && !seen; i++) begin
            @(posedge clk); #1;
            if (on_if ? if_done : mem_done) begin
                seen = 1'b1; n = i;
                if (on_if) if_req = 1'b0; else mem_req = 1'b0;
            end
        end
        chk(tag, n, exp_lat);
        @(posedge clk); #1;
    endtask

    task automatic contend(input string tag, input bit exp_mem_first);
        bit first_mem, seen;
        int n;
        first_mem = 1'b0; seen = 1'b0; n = 0;
        if_addr = 32'h0000_0100; if_req = 1'b1;
        mem_start(1'b0, 2'd3, 32'h0000_0200, 32'h0);
        @(posedge clk);
        for (int i = 1; i <= 16 && !seen; i++) begin
            @(posedge clk); #1;
            if (mem_done) begin
                seen = 1'b1; first_mem = 1'b1; n = i; mem_req = 1'b0;
            end else if (if_done) begin
                seen = 1'b1; n = i; if_req = 1'b0;
            end
        end
        chk({tag, "_mem_first"}, first_mem, exp_mem_first);
        chk({tag, "_lat1"}, n, 5);
        wait_done({tag, "_lat2"}, first_mem, 5);
        chk({tag, "_mem_rdata"}, mem_rdata, 32'h1234_5678);
        chk({tag, "_if_data"}, if_data, 32'h0000_0013);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] wrap_exp [4];
        logic [1:0]  rd_len [4];
        logic [31:0] rd_addr [4];
        logic [31:0] rd_exp [4];
        int          rd_lat [4];
        int          pulses0;

        rst = 1'b1; pre_we = 1'b0; pre_a = 32'h0; pre_d = 8'h00;
        if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;

        poke(32'h0000_0100, 8'h13); poke(32'h0000_0101, 8'h00);
        poke(32'h0000_0102, 8'h00); poke(32'h0000_0103, 8'h00);
        poke(32'h0000_0200, 8'h78); poke(32'h0000_0201, 8'h56);
        poke(32'h0000_0202, 8'h34); poke(32'h0000_0203, 8'h12);
        poke(32'h0000_1003, 8'h11); poke(32'h0000_1004, 8'h55);
        poke(32'hFFFF_FFFE, 8'hA1); poke(32'hFFFF_FFFF, 8'hB2);
        poke(32'h0000_0000, 8'hC3); poke(32'h0000_0001, 8'hD4);
        poke(32'h0000_3001, 8'h00);

        chk("rst_addr_ram", addr_ram, 32'h0);
        chk("rst_dout_ram", dout_ram, 32'h0);
        chk("rst_wr_ram", wr_ram, 32'h0);
        chk("rst_if_done", if_done, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_mem_done", mem_done, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // last_grant is IF out of reset, so MEM wins first contention.
        contend("c1", 1'b1);

        mem_start(1'b1, 2'd0, 32'h0000_1003, 32'hAABB_CCDD);
        @(posedge clk); #1;
        chk("bw_wr", wr_ram, 32'h1);
        chk("bw_addr", addr_ram, 32'h0000_1003);
        chk("bw_dout", dout_ram, 32'h0000_00DD);
        @(posedge clk); #1;
        chk("bw_done", mem_done, 32'h1);
        chk("bw_wr_off", wr_ram, 32'h0);
        mem_req = 1'b0;
        @(posedge clk); #1;
        chk("bw_done_pulse", mem_done, 32'h0);
        chk("bw_ram_1003", ram[ram_idx(32'h0000_1003)], 32'h0000_00DD);
        chk("bw_ram_1004", ram[ram_idx(32'h0000_1004)], 32'h0000_0055);

        // last_grant is MEM now: IF wins, and keeps winning as MEM follows it.
        contend("c2", 1'b0);
        contend("c3", 1'b0);

        if_addr = 32'h0000_0100; if_req = 1'b1; if_flush = 1'b1;
        @(posedge clk); #1;
        if_flush = 1'b0;
        wait_done("flush_idle_lat", 1'b1, 5);

        pulses0 = if_pulses;
        if_addr = 32'h0000_0200; if_req = 1'b1;
        @(posedge clk); #1;
        mem_start(1'b0, 2'd0, 32'h0000_1003, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        if_flush = 1'b1; if_req = 1'b0;
        @(posedge clk); #1;
        if_flush = 1'b0;
        chk("fl_no_done", if_done, 32'h0);
        wait_done("fl_mem_lat", 1'b0, 2);
        chk("fl_mem_rdata", mem_rdata, 32'h0000_00DD);
        chk("fl_if_data", if_data, 32'h0000_0013);
        chk("fl_if_pulses", if_pulses - pulses0, 32'h0);

        mem_start(1'b1, 2'd3, 32'h0000_2000, 32'h4433_2211);
        wait_done("ww_lat", 1'b0, 4);
        chk("ww_ram_2000", ram[ram_idx(32'h0000_2000)], 32'h0000_0011);
        chk("ww_ram_2003", ram[ram_idx(32'h0000_2003)], 32'h0000_0044);

        rd_len  = '{2'd3, 2'd1, 2'd0, 2'd2};
        rd_addr = '{32'h0000_2000, 32'h0000_2001, 32'h0000_2003, 32'h0000_2000};
        rd_exp  = '{32'h4433_2211, 32'h0000_3322, 32'h0000_0044, 32'h4433_2211};
        rd_lat  = '{5, 3, 2, 5};
        for (int k = 0; k < 4; k++) begin
            mem_start(1'b0, rd_len[k], rd_addr[k], 32'h0);
            wait_done($sformatf("rd%0d_lat", k), 1'b0, rd_lat[k]);
            chk($sformatf("rd%0d_data", k), mem_rdata, rd_exp[k]);
        end

        wrap_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        mem_start(1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("wrap_addr%0d", k), addr_ram, wrap_exp[k]);
        end
        @(posedge clk); #1;
        chk("wrap_early", mem_done, 32'h0);
        @(posedge clk); #1;
        chk("wrap_done", mem_done, 32'h1);
        mem_req = 1'b0;
        chk("wrap_rdata", mem_rdata, 32'hD4C3_B2A1);
        @(posedge clk); #1;

        pulses0 = mem_pulses;
        mem_start(1'b1, 2'd3, 32'h0000_3000, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_ram", wr_ram, 32'h0);
        chk("arst_addr_ram", addr_ram, 32'h0);
        chk("arst_dout_ram", dout_ram, 32'h0);
        chk("arst_if_data", if_data, 32'h0);
        chk("arst_mem_rdata", mem_rdata, 32'h0);
        mem_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("arst_no_done", mem_pulses - pulses0, 32'h0);
        chk("arst_wr_idle", wr_ram, 32'h0);
        mem_start(1'b0, 2'd1, 32'h0000_3000, 32'h0);
        wait_done("arst_fresh_lat", 1'b0, 3);
        chk("arst_fresh_data", mem_rdata, 32'h0000_00EF);

        chk("done_overlap", both_hi, 32'h0);
        chk("done_stretch", long_pulse, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
